// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 scan code set 2 keyboard decoder.
package ps2_kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_E0    = 2'd1,
    ST_F0    = 2'd2,
    ST_PAUSE = 2'd3
  } state_e;

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_F0 = 8'hF0;
  localparam logic [7:0] BYTE_E1 = 8'hE1;
  localparam logic [7:0] BYTE_FA = 8'hFA;
  localparam logic [7:0] BYTE_AA = 8'hAA;
  localparam logic [7:0] BYTE_EE = 8'hEE;
  localparam logic [7:0] BYTE_FE = 8'hFE;
  localparam logic [7:0] BYTE_FC = 8'hFC;
  localparam logic [7:0] BYTE_00 = 8'h00;
  localparam logic [7:0] BYTE_FF = 8'hFF;

  // Left/right shift codes the keyboard injects around E0 keys in some modes.
  localparam logic [7:0] BYTE_FAKE_LSHIFT = 8'h12;
  localparam logic [7:0] BYTE_FAKE_RSHIFT = 8'h59;

  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  localparam int EV_CODE_LSB = 0;
  localparam int EV_BRK_BIT  = 8;
  localparam int EV_EXT_BIT  = 9;
  localparam int EV_WIDTH    = 10;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_event_t;

  function automatic logic is_ctrl_byte(input logic [7:0] b);
    return (b == BYTE_FA) || (b == BYTE_AA) || (b == BYTE_EE) || (b == BYTE_FE) ||
           (b == BYTE_FC) || (b == BYTE_00) || (b == BYTE_FF);
  endfunction

endpackage

// File: rtl/ps2_key_fifo.sv
// Synchronous show-ahead FIFO: rdata always presents the head entry.
module ps2_key_fifo #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  drop
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  push_ok, pop_ok;

  always_comb begin
    full    = (count_q == (ADDR_WIDTH+1)'(DEPTH));
    empty   = (count_q == '0);
    pop_ok  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    push_ok = push & (~full | pop_ok);
    drop    = push & ~push_ok;

    wr_ptr_d = push_ok ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    count_d  = count_q + (ADDR_WIDTH+1)'(push_ok) - (ADDR_WIDTH+1)'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; entries are only visible once count marks them valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Scan code set 2 decoder (E0/F0/E1 prefixes) feeding a key-event FIFO; control bytes strobe out.
// Optional auto-repeat suppression when PS2_KBD_TYPEMATIC_FILTER_EN is defined.
module ps2_scancode_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH      = 8,
  parameter int FIFO_ADDR_WIDTH = 3,
  parameter int TIMEOUT_CYCLES  = 1000000,
  parameter int TIMEOUT_WIDTH   = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               received_data,
  input  logic                     received_data_en,
  input  logic                     key_ready,
  input  logic                     clear_overflow,
  output logic                     key_valid,
  output logic [7:0]               key_code,
  output logic                     key_extended,
  output logic                     key_break,
  output logic [FIFO_ADDR_WIDTH:0] fifo_count,
  output logic                     overflow,
  output logic                     ctrl_byte_en,
  output logic [7:0]               ctrl_byte
);

  localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e                   state_q, state_d;
  logic                     ext_q, ext_d;
  logic [2:0]               skip_q, skip_d;
  logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
  logic                     ctrl_en_q, ctrl_en_d;
  logic [7:0]               ctrl_byte_q, ctrl_byte_d;
  logic                     overflow_q, overflow_d;

  key_event_t ev;
  logic       ev_push;
  logic       fifo_push;
  key_event_t head;
  logic       fifo_full, fifo_empty, fifo_drop;

  always_comb begin
    state_d     = state_q;
    ext_d       = ext_q;
    skip_d      = skip_q;
    tmo_d       = '0;
    ctrl_en_d   = 1'b0;
    ctrl_byte_d = ctrl_byte_q;
    ev_push     = 1'b0;
    ev          = '0;

    // Abandon a stalled prefix so a lost byte cannot corrupt the next key.
    if (state_q != ST_IDLE && !received_data_en) begin
      if (tmo_q == TMO_LAST) begin
        state_d = ST_IDLE;
        ext_d   = 1'b0;
        skip_d  = '0;
      end else begin
        tmo_d = tmo_q + TIMEOUT_WIDTH'(1);
      end
    end

    if (received_data_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (received_data == BYTE_E0) begin
            state_d = ST_E0;
          end else if (received_data == BYTE_F0) begin
            state_d = ST_F0;
            ext_d   = 1'b0;
          end else if (received_data == BYTE_E1) begin
            state_d = ST_PAUSE;
            skip_d  = PAUSE_SKIP;
          end else if (is_ctrl_byte(received_data)) begin
            ctrl_en_d   = 1'b1;
            ctrl_byte_d = received_data;
          end else begin
            ev_push = 1'b1;
            ev      = '{ext: 1'b0, brk: 1'b0, code: received_data};
          end
        end
        ST_E0: begin
          if (received_data == BYTE_F0) begin
            state_d = ST_F0;
            ext_d   = 1'b1;
          end else if (received_data == BYTE_E0) begin
            state_d = ST_E0;
          end else if (received_data == BYTE_FAKE_LSHIFT || received_data == BYTE_FAKE_RSHIFT) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_IDLE;
            ev_push = 1'b1;
            ev      = '{ext: 1'b1, brk: 1'b0, code: received_data};
          end
        end
        ST_F0: begin
          state_d = ST_IDLE;
          ext_d   = 1'b0;
          ev_push = 1'b1;
          ev      = '{ext: ext_q, brk: 1'b1, code: received_data};
        end
        ST_PAUSE: begin
          if (skip_q <= 3'd1) begin
            state_d = ST_IDLE;
            skip_d  = '0;
            ev_push = 1'b1;
            ev      = '{ext: 1'b0, brk: 1'b0, code: BYTE_E1};
          end else begin
            skip_d = skip_q - 3'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

`ifdef PS2_KBD_TYPEMATIC_FILTER_EN
  logic       filt_vld_q, filt_vld_d;
  logic [8:0] filt_q, filt_d;

  always_comb begin
    fifo_push  = ev_push;
    filt_vld_d = filt_vld_q;
    filt_d     = filt_q;
    if (ev_push) begin
      if (!ev.brk) begin
        // Pause has no break code, so repeated Pause presses must never be swallowed.
        if (state_q != ST_PAUSE && filt_vld_q && filt_q == {ev.ext, ev.code}) begin
          fifo_push = 1'b0;
        end else begin
          filt_vld_d = 1'b1;
          filt_d     = {ev.ext, ev.code};
        end
      end else if (filt_vld_q && filt_q == {ev.ext, ev.code}) begin
        filt_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_vld_q <= 1'b0;
      filt_q     <= '0;
    end else begin
      filt_vld_q <= filt_vld_d;
      filt_q     <= filt_d;
    end
  end
`else
  assign fifo_push = ev_push;
`endif

  always_comb begin
    overflow_d = overflow_q;
    if (clear_overflow) overflow_d = 1'b0;
    if (fifo_drop)      overflow_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only; next values come from always_comb.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ext_q       <= 1'b0;
      skip_q      <= '0;
      tmo_q       <= '0;
      ctrl_en_q   <= 1'b0;
      ctrl_byte_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ext_q       <= ext_d;
      skip_q      <= skip_d;
      tmo_q       <= tmo_d;
      ctrl_en_q   <= ctrl_en_d;
      ctrl_byte_q <= ctrl_byte_d;
      overflow_q  <= overflow_d;
    end
  end

  ps2_key_fifo #(
    .DEPTH      (FIFO_DEPTH),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH),
    .DATA_WIDTH (EV_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (ev),
    .pop   (key_ready),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .drop  (fifo_drop)
  );

  assign key_valid    = ~fifo_empty;
  assign key_code     = key_valid ? head.code : 8'h00;
  assign key_extended = key_valid & head.ext;
  assign key_break    = key_valid & head.brk;
  assign overflow     = overflow_q;
  assign ctrl_byte_en = ctrl_en_q;
  assign ctrl_byte    = ctrl_byte_q;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: byte-sequence vector table plus multi-cycle corner cases.
module tb_ps2_scancode_decoder;

  localparam int TMO  = 40;
  localparam int NVEC = 13;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] received_data = 8'h00;
  logic       received_data_en = 1'b0;
  logic       key_ready = 1'b0;
  logic       clear_overflow = 1'b0;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_break;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       ctrl_byte_en;
  logic [7:0] ctrl_byte;

  int checks = 0;
  int errors = 0;

  logic [9:0] got[$];
  logic [7:0] ctrl_got[$];

  typedef struct {
    int              nb;
    logic [0:7][7:0] b;
    int              ne;
    logic [0:4][9:0] e;
    logic            hc;
    logic [7:0]      c;
  } vec_t;

  vec_t vecs[NVEC];

  ps2_scancode_decoder #(
    .FIFO_DEPTH      (8),
    .FIFO_ADDR_WIDTH (3),
    .TIMEOUT_CYCLES  (TMO),
    .TIMEOUT_WIDTH   (6)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .received_data    (received_data),
    .received_data_en (received_data_en),
    .key_ready        (key_ready),
    .clear_overflow   (clear_overflow),
    .key_valid        (key_valid),
    .key_code         (key_code),
    .key_extended     (key_extended),
    .key_break        (key_break),
    .fifo_count       (fifo_count),
    .overflow         (overflow),
    .ctrl_byte_en     (ctrl_byte_en),
    .ctrl_byte        (ctrl_byte)
  );

  always #5 clk = ~clk;

  // Record every entry actually handed to the consumer and every control strobe.
  always @(negedge clk) begin
    if (!reset && key_valid && key_ready) got.push_back({key_extended, key_break, key_code});
    if (!reset && ctrl_byte_en) ctrl_got.push_back(ctrl_byte);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    received_data_en = 1'b0;
    clear_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    received_data = b;
    received_data_en = 1'b1;
    @(posedge clk); #1;
    received_data_en = 1'b0;
  endtask

  initial begin
    // {ext,brk,code} entries; byte and entry lists are left-aligned.
    vecs[0]  = '{nb:1, b:{8'h1C, 56'h0}, ne:1, e:{10'h01C, 40'h0}, hc:1'b0, c:8'h00};
    vecs[1]  = '{nb:3, b:{8'hE0, 8'hF0, 8'h75, 40'h0}, ne:1, e:{10'h375, 40'h0}, hc:1'b0, c:8'h00};
    vecs[2]  = '{nb:4, b:{8'hE0, 8'h12, 8'hE0, 8'h7C, 32'h0}, ne:1, e:{10'h27C, 40'h0}, hc:1'b0, c:8'h00};
    vecs[3]  = '{nb:8, b:{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77}, ne:1,
                 e:{10'h0E1, 40'h0}, hc:1'b0, c:8'h00};
    vecs[4]  = '{nb:1, b:{8'hFA, 56'h0}, ne:0, e:50'h0, hc:1'b1, c:8'hFA};
    vecs[5]  = '{nb:2, b:{8'hF0, 8'h1C, 48'h0}, ne:1, e:{10'h11C, 40'h0}, hc:1'b0, c:8'h00};
    vecs[6]  = '{nb:3, b:{8'hE0, 8'hE0, 8'h75, 40'h0}, ne:1, e:{10'h275, 40'h0}, hc:1'b0, c:8'h00};
    vecs[7]  = '{nb:2, b:{8'hE0, 8'h59, 48'h0}, ne:0, e:50'h0, hc:1'b0, c:8'h00};
    vecs[8]  = '{nb:1, b:{8'hAA, 56'h0}, ne:0, e:50'h0, hc:1'b1, c:8'hAA};
    vecs[9]  = '{nb:1, b:{8'h00, 56'h0}, ne:0, e:50'h0, hc:1'b1, c:8'h00};
    vecs[10] = '{nb:2, b:{8'hE0, 8'hFA, 48'h0}, ne:1, e:{10'h2FA, 40'h0}, hc:1'b0, c:8'h00};
    vecs[11] = '{nb:2, b:{8'hF0, 8'hAA, 48'h0}, ne:1, e:{10'h1AA, 40'h0}, hc:1'b0, c:8'h00};
`ifdef PS2_KBD_TYPEMATIC_FILTER_EN
    vecs[12] = '{nb:6, b:{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C, 16'h0}, ne:3,
                 e:{10'h01C, 10'h11C, 10'h01C, 20'h0}, hc:1'b0, c:8'h00};
`else
    vecs[12] = '{nb:6, b:{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C, 16'h0}, ne:5,
                 e:{10'h01C, 10'h01C, 10'h01C, 10'h11C, 10'h01C}, hc:1'b0, c:8'h00};
`endif

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst key_valid", key_valid, 0);
    check("rst fifo_count", fifo_count, 0);
    check("rst overflow", overflow, 0);
    check("rst ctrl_byte_en", ctrl_byte_en, 0);
    check("rst ctrl_byte", ctrl_byte, 0);
    check("rst key_code", {key_extended, key_break, key_code}, 0);
    #1 reset = 1'b0;

    // Table-driven sequences, consumer always ready
    for (int i = 0; i < NVEC; i++) begin
      do_reset();
      got.delete();
      ctrl_got.delete();
      key_ready = 1'b1;
      for (int j = 0; j < vecs[i].nb; j++) send_byte(vecs[i].b[j]);
      repeat (6) @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d entries", i), got.size(), vecs[i].ne);
      for (int j = 0; j < vecs[i].ne; j++)
        if (j < got.size()) check($sformatf("v%0d entry%0d", i, j), got[j], vecs[i].e[j]);
      check($sformatf("v%0d ctrl strobes", i), ctrl_got.size(), vecs[i].hc ? 1 : 0);
      if (vecs[i].hc) begin
        if (ctrl_got.size() > 0) check($sformatf("v%0d ctrl strobe byte", i), ctrl_got[0], vecs[i].c);
        check($sformatf("v%0d ctrl_byte held", i), ctrl_byte, vecs[i].c);
      end
      check($sformatf("v%0d fifo_count", i), fifo_count, 0);
    end

    // Write latency and show-ahead head
    do_reset();
    key_ready = 1'b0;
    @(posedge clk); #1;
    received_data = 8'h1C;
    received_data_en = 1'b1;
    @(negedge clk);
    check("lat valid in N", key_valid, 0);
    @(posedge clk); #1 received_data_en = 1'b0;
    @(negedge clk);
    check("lat valid in N+1", key_valid, 1);
    check("lat count", fifo_count, 1);
    check("lat head", {key_extended, key_break, key_code}, 10'h01C);
    @(posedge clk); #1 key_ready = 1'b1;
    @(posedge clk); #1 key_ready = 1'b0;
    @(negedge clk);
    check("pop count", fifo_count, 0);
    check("pop valid", key_valid, 0);

    // Control byte strobe timing
    @(posedge clk); #1;
    received_data = 8'hFE;
    received_data_en = 1'b1;
    @(negedge clk);
    check("ctrl en in N", ctrl_byte_en, 0);
    @(posedge clk); #1 received_data_en = 1'b0;
    @(negedge clk);
    check("ctrl en in N+1", ctrl_byte_en, 1);
    check("ctrl byte in N+1", ctrl_byte, 8'hFE);
    @(negedge clk);
    check("ctrl en one cycle", ctrl_byte_en, 0);
    check("ctrl byte holds", ctrl_byte, 8'hFE);
    check("ctrl no entry", fifo_count, 0);

    // Overflow: nine makes into an eight-entry FIFO with no consumer
    do_reset();
    key_ready = 1'b0;
    for (int k = 1; k <= 9; k++) send_byte(8'(k));
    @(negedge clk);
    check("ovf count", fifo_count, 8);
    check("ovf flag", overflow, 1);
    check("ovf head", {key_extended, key_break, key_code}, 10'h001);
    @(posedge clk); #1;
    clear_overflow = 1'b1;
    received_data = 8'h0B;
    received_data_en = 1'b1;
    @(posedge clk); #1;
    clear_overflow = 1'b0;
    received_data_en = 1'b0;
    @(negedge clk);
    check("ovf clear vs new drop", overflow, 1);
    check("ovf count after drop", fifo_count, 8);
    @(posedge clk); #1 clear_overflow = 1'b1;
    @(posedge clk); #1 clear_overflow = 1'b0;
    @(negedge clk);
    check("ovf cleared", overflow, 0);
    got.delete();
    @(posedge clk); #1;
    key_ready = 1'b1;
    received_data = 8'h0A;
    received_data_en = 1'b1;
    @(posedge clk); #1;
    key_ready = 1'b0;
    received_data_en = 1'b0;
    @(negedge clk);
    check("full push+pop count", fifo_count, 8);
    check("full push+pop no ovf", overflow, 0);
    check("full push+pop head", key_code, 8'h02);
    @(posedge clk); #1 key_ready = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("drain entries", got.size(), 9);
    if (got.size() == 9) begin
      check("drain first", got[0], 10'h001);
      check("drain second", got[1], 10'h002);
      check("drain last", got[8], 10'h00A);
    end
    check("drain count", fifo_count, 0);

    // Timeout: E0 followed by a long gap is abandoned
    do_reset();
    key_ready = 1'b1;
    got.delete();
    send_byte(8'hE0);
    repeat (TMO + 2) @(posedge clk);
    send_byte(8'h1C);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("tmo entries", got.size(), 1);
    if (got.size() > 0) check("tmo ext cleared", got[0], 10'h01C);

    // A strobe in the last cycle before the timeout still continues the prefix
    got.delete();
    send_byte(8'hE0);
    repeat (TMO - 2) @(posedge clk);
    send_byte(8'h7C);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("tmo edge entries", got.size(), 1);
    if (got.size() > 0) check("tmo edge ext kept", got[0], 10'h27C);

    // Reset mid-sequence discards the pending break prefix
    got.delete();
    send_byte(8'hF0);
    do_reset();
    send_byte(8'h1C);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst mid entries", got.size(), 1);
    if (got.size() > 0) check("rst mid make", got[0], 10'h01C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
